// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared FSM state type and default geometry for the row selector
package ram_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      SCAN   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEF_AW   = 3;
   localparam int DEF_HOLD = 1;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - maps a row address to its physical row and decodes it one-hot
module onehot_dec #(
   parameter int AW      = 3,
   parameter int BIT_REV = 1
) (
   input  logic [AW-1:0]     index,
   output logic [2**AW-1:0]  onehot
);

   logic [AW-1:0] row;

   // Legacy arrays wire addr[0] to the decoder MSB, so the index is bit-reversed.
   always_comb begin
      row = index;
      if (BIT_REV != 0) begin
         for (int i = 0; i < AW; i++) begin
            row[i] = index[AW-1-i];
         end
      end
      onehot      = '0;
      onehot[row] = 1'b1;
   end

endmodule

// File: rtl/ram_row_select.sv
// rtl/ram_row_select.sv - single-row and full-array scan row select with per-row hold
module ram_row_select
   import ram_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int HOLD    = DEF_HOLD,
   parameter int BIT_REV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [AW-1:0]     addr,
   output logic              ready,
   input  logic              scan_start,
   output logic [2**AW-1:0]  sel,
   output logic              sel_valid,
   output logic              scan_busy,
   output logic              scan_done,
   output logic [AW-1:0]     cur_addr
);

   localparam int              RW     = 2**AW;
   localparam int              HW     = $clog2(HOLD + 1);
   localparam logic [HW-1:0]   HOLD_V = HW'(HOLD);
   localparam logic [AW-1:0]   LAST   = {AW{1'b1}};

   state_t          state;
   logic [HW-1:0]   hold_cnt;
   logic            hold_end;
   logic [AW-1:0]   next_idx;
   logic [RW-1:0]   next_sel;

   assign ready    = (state == IDLE) && !scan_start;
   assign hold_end = (hold_cnt == HOLD_V);

   // Address that will be current after this edge; decoded ahead so sel is a flop.
   always_comb begin
      next_idx = cur_addr;
      if (state == IDLE) begin
         next_idx = scan_start ? '0 : addr;
      end else if (state == SCAN && hold_end) begin
         next_idx = cur_addr + AW'(1);
      end
   end

   onehot_dec #(
      .AW      (AW),
      .BIT_REV (BIT_REV)
   ) u_dec (
      .index  (next_idx),
      .onehot (next_sel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= '0;
         sel_valid <= 1'b0;
         scan_busy <= 1'b0;
         scan_done <= 1'b0;
         cur_addr  <= '0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (scan_start || req) begin
                  state     <= scan_start ? SCAN : SINGLE;
                  scan_busy <= scan_start;
                  cur_addr  <= next_idx;
                  sel       <= next_sel;
                  sel_valid <= 1'b1;
                  hold_cnt  <= HW'(1);
               end
            end
            SINGLE: begin
               if (hold_end) begin
                  state     <= IDLE;
                  sel       <= '0;
                  sel_valid <= 1'b0;
                  hold_cnt  <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            SCAN: begin
               if (!hold_end) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end else if (cur_addr == LAST) begin
                  // Last row finished: no wrap, single DONE cycle follows.
                  state     <= DONE;
                  sel       <= '0;
                  sel_valid <= 1'b0;
                  scan_busy <= 1'b0;
                  scan_done <= 1'b1;
                  hold_cnt  <= '0;
               end else begin
                  cur_addr <= next_idx;
                  sel      <= next_sel;
                  hold_cnt <= HW'(1);
               end
            end
            DONE: begin
               scan_done <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
